// File: rtl/n64adv_vpll_pkg.sv
// n64adv_vpll_pkg
// Shared definitions for the video PLL manager and every consumer of its
// VPLL_STATE output (for example the OSD), so that all of them decode the
// state identically.
//   vpll_state_e       : FSM state encoding carried on VPLL_STATE
//   *_DEF localparams  : default timing and retry parameters
//   manage_for()       : {USE_VPLL, EN_VPLL} for a given state
package n64adv_vpll_pkg;

   typedef enum logic [2:0] {
      ST_OFF     = 3'd0,
      ST_START   = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_ACTIVE  = 3'd3,
      ST_RESTART = 3'd4,
      ST_STOP    = 3'd5,
      ST_FAIL    = 3'd6
   } vpll_state_e;

   localparam logic [15:0] LOCK_TIMEOUT_DEF  = 16'd50000;
   localparam logic [15:0] SETTLE_CYCLES_DEF = 16'd1000;
   localparam logic [15:0] GUARD_CYCLES_DEF  = 16'd64;
   localparam logic [2:0]  MAX_RETRIES_DEF   = 3'd3;

   // USE is only ever granted in ACTIVE, and ACTIVE always enables the PLL,
   // so USE_VPLL=1 can never be seen together with EN_VPLL=0.
   function automatic logic [1:0] manage_for(input vpll_state_e s);
      logic w_en;
      logic w_use;
      w_en  = (s == ST_START) || (s == ST_SETTLE) || (s == ST_ACTIVE) || (s == ST_STOP);
      w_use = (s == ST_ACTIVE);
      return {w_use, w_en};
   endfunction

endpackage

// File: rtl/register_sync.sv
// register_sync
// Multi-stage flip-flop synchronizer for bringing asynchronous signals into
// the i_clk domain. Every stage clears on reset.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset
//   i_d     : asynchronous input  [WIDTH-1:0]
//   o_q     : synchronized output [WIDTH-1:0], lags i_d by STAGES cycles
module register_sync #(
   parameter int unsigned STAGES = 2,
   parameter int unsigned WIDTH  = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_pipe [STAGES];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned i = 0; i < STAGES; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= i_d;
         for (int unsigned i = 1; i < STAGES; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign o_q = r_pipe[STAGES-1];

endmodule

// File: rtl/n64adv_vpll_manager.sv
// n64adv_vpll_manager
// Sequences the video PLL: it enables the PLL, waits for lock, requires the
// lock to stay stable before switching the PPU over to the PLL clock, and
// tears the PLL down in an orderly way when the PLL is no longer requested
// or when lock is lost.
//   SYS_CLK         : the single clock
//   nSRST           : asynchronous active-low reset
//   VPLL_REQ        : configuration requests the VPLL clock (SYS_CLK domain)
//   VCLK_PLL_LOCKED : raw PLL lock, asynchronous to SYS_CLK
//   MANAGE_VPLL     : [1] USE_VPLL, [0] EN_VPLL (registered)
//   VPLL_FAIL       : sticky failure flag, cleared on return to OFF (registered)
//   VPLL_STATE      : current state, encoded as n64adv_vpll_pkg::vpll_state_e
// Build option: define VPLL_AUTO_RETRY_EN to retry the lock through RESTART
// before declaring FAIL. Without it, a START timeout or a lock loss in
// ACTIVE goes straight to FAIL and the retry counter does not exist.
module n64adv_vpll_manager
   import n64adv_vpll_pkg::*;
#(
   parameter logic [15:0] LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
   parameter logic [15:0] SETTLE_CYCLES = SETTLE_CYCLES_DEF,
   parameter logic [15:0] GUARD_CYCLES  = GUARD_CYCLES_DEF,
   parameter logic [2:0]  MAX_RETRIES   = MAX_RETRIES_DEF
) (
   input  logic       SYS_CLK,
   input  logic       nSRST,
   input  logic       VPLL_REQ,
   input  logic       VCLK_PLL_LOCKED,
   output logic [1:0] MANAGE_VPLL,
   output logic       VPLL_FAIL,
   output logic [2:0] VPLL_STATE
);

   vpll_state_e r_state;
   vpll_state_e w_next;
   logic [15:0] r_cnt;
   logic [1:0]  r_manage;
   logic        r_fail;
   logic        w_lock_s;
   logic        w_lost;

   register_sync #(.STAGES(2), .WIDTH(1)) u_lock_sync (
      .i_clk   (SYS_CLK),
      .i_rst_n (nSRST),
      .i_d     (VCLK_PLL_LOCKED),
      .o_q     (w_lock_s)
   );

`ifdef VPLL_AUTO_RETRY_EN
   logic [2:0] r_retry;
   logic       w_retry_inc;
   logic       w_retry_clr;
`endif

   // w_lost marks a START timeout or an ACTIVE lock loss; both share the
   // retry decision after the case. A dropped VPLL_REQ is checked first in
   // every state so it wins over a coincident lock event or timeout.
   always_comb begin
      w_next = r_state;
      w_lost = 1'b0;
`ifdef VPLL_AUTO_RETRY_EN
      w_retry_inc = 1'b0;
      w_retry_clr = 1'b0;
`endif
      unique case (r_state)
         ST_OFF:     if (VPLL_REQ) w_next = ST_START;
         ST_START: begin
            if (!VPLL_REQ)                            w_next = ST_STOP;
            else if (w_lock_s)                        w_next = ST_SETTLE;
            else if (r_cnt == LOCK_TIMEOUT - 16'd1)   w_lost = 1'b1;
         end
         ST_SETTLE: begin
            if (!VPLL_REQ)                            w_next = ST_STOP;
            else if (!w_lock_s)                       w_next = ST_START;
            else if (r_cnt == SETTLE_CYCLES - 16'd1)  w_next = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (!VPLL_REQ)                            w_next = ST_STOP;
            else if (!w_lock_s)                       w_lost = 1'b1;
         end
         ST_RESTART: begin
            if (!VPLL_REQ)                            w_next = ST_OFF;
            else if (r_cnt == GUARD_CYCLES - 16'd1)   w_next = ST_START;
         end
         ST_STOP:    if (r_cnt == GUARD_CYCLES - 16'd1) w_next = ST_OFF;
         ST_FAIL:    if (!VPLL_REQ) w_next = ST_OFF;
         default:    w_next = ST_OFF;
      endcase

      if (w_lost) begin
`ifdef VPLL_AUTO_RETRY_EN
         if (r_retry < MAX_RETRIES - 3'd1) begin
            w_next      = ST_RESTART;
            w_retry_inc = 1'b1;
         end else begin
            w_next = ST_FAIL;
         end
`else
         w_next = ST_FAIL;
`endif
      end

`ifdef VPLL_AUTO_RETRY_EN
      w_retry_clr = ((w_next == ST_ACTIVE) && (r_state != ST_ACTIVE)) ||
                    ((r_state == ST_FAIL) && (w_next == ST_OFF));
`endif
   end

   // Outputs are computed from the next state so they change on the same
   // edge that enters the state.
   always_ff @(posedge SYS_CLK or negedge nSRST) begin
      if (!nSRST) begin
         r_state  <= ST_OFF;
         r_cnt    <= '0;
         r_manage <= '0;
         r_fail   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state)  r_cnt <= '0;
         else if (r_cnt != '1)   r_cnt <= r_cnt + 16'd1;
         r_manage <= manage_for(w_next);
         r_fail   <= (w_next == ST_FAIL);
      end
   end

`ifdef VPLL_AUTO_RETRY_EN
   always_ff @(posedge SYS_CLK or negedge nSRST) begin
      if (!nSRST)           r_retry <= '0;
      else if (w_retry_clr) r_retry <= '0;
      else if (w_retry_inc) r_retry <= r_retry + 3'd1;
   end
`endif

   assign MANAGE_VPLL = r_manage;
   assign VPLL_FAIL   = r_fail;
   assign VPLL_STATE  = r_state;

endmodule

// File: tb/tb_n64adv_vpll_manager.sv
module tb_n64adv_vpll_manager;

   localparam logic [2:0] S_OFF     = 3'd0;
   localparam logic [2:0] S_START   = 3'd1;
   localparam logic [2:0] S_SETTLE  = 3'd2;
   localparam logic [2:0] S_ACTIVE  = 3'd3;
   localparam logic [2:0] S_RESTART = 3'd4;
   localparam logic [2:0] S_STOP    = 3'd5;
   localparam logic [2:0] S_FAIL    = 3'd6;

   typedef struct packed {
      logic [2:0] st;
      logic [1:0] mg;
      logic       f;
   } exp_t;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       req   = 1'b0;
   logic       lock  = 1'b0;
   logic [1:0] manage;
   logic       fail;
   logic [2:0] state;

   exp_t  exp_q[$];
   string tag_q[$];
   int    vectors     = 0;
   int    miscompares = 0;

   n64adv_vpll_manager #(
      .LOCK_TIMEOUT  (16'd16),
      .SETTLE_CYCLES (16'd8),
      .GUARD_CYCLES  (16'd4),
      .MAX_RETRIES   (3'd2)
   ) dut (
      .SYS_CLK         (clk),
      .nSRST           (rst_n),
      .VPLL_REQ        (req),
      .VCLK_PLL_LOCKED (lock),
      .MANAGE_VPLL     (manage),
      .VPLL_FAIL       (fail),
      .VPLL_STATE      (state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed t=%0t required end before 200000", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic push(input logic [2:0] st, input logic en, input logic use_, input logic f,
                       input string tag);
      exp_t e;
      e.st = st;
      e.mg = {use_, en};
      e.f  = f;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic compare();
      exp_t  e;
      exp_t  o;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o.st = state;
      o.mg = manage;
      o.f  = fail;
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s: observed state=%0d manage=%b fail=%b, expected state=%0d manage=%b fail=%b",
                t, o.st, o.mg, o.f, e.st, e.mg, e.f);
      end
   endtask

   // Expectation for the state entered on the next rising edge.
   task automatic cyc(input logic [2:0] st, input logic en, input logic use_, input logic f,
                      input string tag);
      push(st, en, use_, f, tag);
      @(posedge clk);
      #1;
      compare();
   endtask

   // Expectation checked right now, without waiting for a clock edge.
   task automatic now_chk(input logic [2:0] st, input logic en, input logic use_, input logic f,
                          input string tag);
      push(st, en, use_, f, tag);
      compare();
   endtask

   initial begin
      // reset asserted away from any clock edge
      #2 rst_n = 1'b0;
      #1 now_chk(S_OFF, 0, 0, 0, "reset_initial");
      #25 rst_n = 1'b1;
      cyc(S_OFF, 0, 0, 0, "off_idle");

      // request with lock rising five cycles later
      req = 1'b1;
      for (int k = 0; k < 7; k++) begin
         if (k == 5) lock = 1'b1;
         cyc(S_START, 1, 0, 0, "start_wait_lock");
      end
      for (int k = 0; k < 8; k++) cyc(S_SETTLE, 1, 0, 0, "settle");
      cyc(S_ACTIVE, 1, 1, 0, "active_entry");
      cyc(S_ACTIVE, 1, 1, 0, "active_hold");

      // request dropped in ACTIVE, re-raised while STOP is running
      req = 1'b0;
      cyc(S_STOP, 1, 0, 0, "stop_0");
      cyc(S_STOP, 1, 0, 0, "stop_1");
      req = 1'b1;
      cyc(S_STOP, 1, 0, 0, "stop_2");
      cyc(S_STOP, 1, 0, 0, "stop_3");
      cyc(S_OFF, 0, 0, 0, "stop_to_off");
      cyc(S_START, 1, 0, 0, "rereq_start");
      cyc(S_SETTLE, 1, 0, 0, "rereq_settle_a");

      // three-cycle lock glitch while settling
      lock = 1'b0;
      cyc(S_SETTLE, 1, 0, 0, "glitch_settle_a");
      cyc(S_SETTLE, 1, 0, 0, "glitch_settle_b");
      cyc(S_START, 1, 0, 0, "glitch_back_start");
      lock = 1'b1;
      cyc(S_START, 1, 0, 0, "glitch_start_a");
      cyc(S_START, 1, 0, 0, "glitch_start_b");
      for (int k = 0; k < 8; k++) cyc(S_SETTLE, 1, 0, 0, "glitch_resettle");
      cyc(S_ACTIVE, 1, 1, 0, "glitch_active");

      // lock lost in ACTIVE
      lock = 1'b0;
      cyc(S_ACTIVE, 1, 1, 0, "loss_t0");
      cyc(S_ACTIVE, 1, 1, 0, "loss_t1");
`ifdef VPLL_AUTO_RETRY_EN
      for (int k = 0; k < 4; k++) cyc(S_RESTART, 0, 0, 0, "loss_restart");
      for (int k = 0; k < 16; k++) cyc(S_START, 1, 0, 0, "loss_retry_start");
      cyc(S_FAIL, 0, 0, 1, "loss_retry_fail");
`else
      cyc(S_FAIL, 0, 0, 1, "loss_fail");
`endif
      cyc(S_FAIL, 0, 0, 1, "fail_sticky");

      // reset in the middle of FAIL
      #2 rst_n = 1'b0;
      #1 now_chk(S_OFF, 0, 0, 0, "reset_mid_fail");
      req = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      cyc(S_OFF, 0, 0, 0, "post_reset_off");

      // lock never arrives
      req = 1'b1;
      for (int k = 0; k < 16; k++) cyc(S_START, 1, 0, 0, "nolock_start1");
`ifdef VPLL_AUTO_RETRY_EN
      for (int k = 0; k < 4; k++) cyc(S_RESTART, 0, 0, 0, "nolock_restart");
      for (int k = 0; k < 16; k++) cyc(S_START, 1, 0, 0, "nolock_start2");
`endif
      cyc(S_FAIL, 0, 0, 1, "nolock_fail");
      req = 1'b0;
      cyc(S_OFF, 0, 0, 0, "fail_clear_off");

      // reach ACTIVE again, then reset mid-ACTIVE
      req  = 1'b1;
      lock = 1'b1;
      cyc(S_START, 1, 0, 0, "act2_start_a");
      cyc(S_START, 1, 0, 0, "act2_start_b");
      for (int k = 0; k < 8; k++) cyc(S_SETTLE, 1, 0, 0, "act2_settle");
      cyc(S_ACTIVE, 1, 1, 0, "act2_active");
      #2 rst_n = 1'b0;
      #1 now_chk(S_OFF, 0, 0, 0, "reset_mid_active");
      @(posedge clk);
      #1 now_chk(S_OFF, 0, 0, 0, "reset_held_on_edge");
      req = 1'b0;
      #2 rst_n = 1'b1;
      cyc(S_OFF, 0, 0, 0, "post_reset_off2");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/n64adv_vpll_manager.md
N64ADV_VPLL_MANAGER -- requirements
Module: n64adv_vpll_manager

Interface
REQ-001 SHALL have parameter LOCK_TIMEOUT, default 16'd50000, meaning max cycles in START waiting for lock.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 16'd1000, meaning cycles lock must hold stable before switchover.
REQ-003 SHALL have parameter GUARD_CYCLES, default 16'd64, meaning PLL-disable hold time in RESTART and STOP.
REQ-004 SHALL have parameter MAX_RETRIES, default 3'd3, meaning lock attempts permitted before FAIL.
REQ-005 SHALL have port SYS_CLK, input, 1 bit: the single clock.
REQ-006 SHALL have port nSRST, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port VPLL_REQ, input, 1 bit: configuration requests VPLL output clock; synchronous to SYS_CLK.
REQ-008 SHALL have port VCLK_PLL_LOCKED, input, 1 bit: raw PLL lock, asynchronous to SYS_CLK.
REQ-009 SHALL have port MANAGE_VPLL, output, 2 bits: [1] USE_VPLL (PPU switches to VCLK_VPLL), [0] EN_VPLL (PLL out of reset).
REQ-010 SHALL have port VPLL_FAIL, output, 1 bit: sticky failure flag for the OSD.
REQ-011 SHALL have port VPLL_STATE, output, 3 bits: current FSM state encoding.

Function
REQ-012 SHALL pass VCLK_PLL_LOCKED through a 2-flop synchronizer (lock_s); lock_s lags the raw input by 2 cycles.
REQ-013 SHALL register all outputs; each output reflects the state entered on the same edge.
REQ-014 SHALL use states OFF=0, START=1, SETTLE=2, ACTIVE=3, RESTART=4, STOP=5, FAIL=6.
REQ-015 SHALL use one shared cycle counter, cleared on every state entry, saturating at its maximum.
REQ-016 OFF: EN=0, USE=0; VPLL_REQ=1 -> START.
REQ-017 START: EN=1, USE=0; lock_s=1 -> SETTLE; counter==LOCK_TIMEOUT-1 with lock_s=0 -> retry decision (REQ-021).
REQ-018 SETTLE: EN=1, USE=0; lock_s=0 -> START without consuming a retry; counter==SETTLE_CYCLES-1 with lock_s=1 -> ACTIVE.
REQ-019 ACTIVE: EN=1, USE=1; entry clears the retry count; lock_s=0 -> retry decision; USE=0 on the edge after lock_s falls.
REQ-020 RESTART: EN=0, USE=0; counter==GUARD_CYCLES-1 -> START.
REQ-021 Retry decision: retry count < MAX_RETRIES-1 -> increment it and enter RESTART; otherwise -> FAIL.
REQ-022 STOP: EN=1, USE=0; counter==GUARD_CYCLES-1 -> OFF regardless of VPLL_REQ; re-request is served from OFF.
REQ-023 FAIL: EN=0, USE=0, VPLL_FAIL=1; VPLL_REQ=0 -> OFF, which clears VPLL_FAIL and the retry count.
REQ-024 VPLL_REQ=0 in START, SETTLE or ACTIVE SHALL enter STOP; this beats a simultaneous lock event or timeout.
REQ-025 VPLL_REQ=0 in RESTART SHALL enter OFF.
REQ-026 USE_VPLL=1 SHALL never occur while EN_VPLL=0 or outside ACTIVE.

Reset
REQ-027 nSRST low SHALL immediately force: state OFF, MANAGE_VPLL=2'b00, VPLL_FAIL=0, counter 0, retry count 0, synchronizer flops 0.
REQ-028 Reset in any state, including mid-ACTIVE, SHALL take effect without a clock edge; operation resumes from OFF after release.

Configuration
REQ-029 With VPLL_AUTO_RETRY_EN defined, the block SHALL implement REQ-021.
REQ-030 Without VPLL_AUTO_RETRY_EN, timeout in START or lock loss in ACTIVE SHALL enter FAIL directly; RESTART becomes unreachable and the retry counter is removed.

Structure
REQ-031 State encodings and parameter defaults SHALL reside in shared package n64adv_vpll_pkg, so the controller and OSD decode VPLL_STATE identically.
REQ-032 The synchronizer SHALL be the sub-module register_sync, instantiated with 2 stages and width 1.

Verification (LOCK_TIMEOUT=16, SETTLE_CYCLES=8, GUARD_CYCLES=4, MAX_RETRIES=2)
REQ-033 VPLL_REQ rises (sampled cycle 0), raw lock rises cycle 5 and holds -> EN=1 from cycle 1, SETTLE entered cycle 8, USE=1 from cycle 16.
REQ-034 Lock never asserted, macro defined -> EN high 16 cycles, low 4, high 16, then FAIL: VPLL_FAIL=1, EN=0; macro undefined -> FAIL after the first 16-cycle START.
REQ-035 3-cycle lock glitch low during SETTLE -> return to START, retry count unchanged, USE stays 0.
REQ-036 In ACTIVE, raw lock falls at cycle t -> USE=0 at t+3, EN=0 in RESTART for 4 cycles, then START.
REQ-037 VPLL_REQ falls in ACTIVE -> USE=0 next cycle, EN held 1 for 4 cycles, then OFF; VPLL_REQ re-raised during STOP -> STOP completes, then START.
REQ-038 nSRST asserted mid-ACTIVE and mid-FAIL -> MANAGE_VPLL=00, VPLL_FAIL=0, VPLL_STATE=0 immediately without a clock edge.
